// File: rtl/wb_master_bridge.sv
// Single-transfer Wishbone B4 classic initiator for internal valid/ready requesters.
// Latency: accept -> cyc next cycle; ack/err/timeout -> rsp_valid next cycle; 3 cycles minimum per transfer.
// Backpressure: req_ready only in IDLE; the response is held until rsp_ready_i, one transfer in flight.
module wb_master_bridge #(
    parameter int unsigned TIMEOUT  = 255,
    parameter logic [31:0] ERR_DATA = 32'hDEAD_BEEF
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_we_i,
    input  logic [31:0] req_adr_i,
    input  logic [31:0] req_dat_i,
    input  logic [3:0]  req_sel_i,
    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic [31:0] rsp_dat_o,
    output logic        rsp_err_o,
    output logic        rsp_timeout_o,
    output logic        wb_cyc_o,
    output logic        wb_stb_o,
    output logic        wb_we_o,
    output logic [31:0] wb_adr_o,
    output logic [31:0] wb_dat_o,
    output logic [3:0]  wb_sel_o,
    input  logic [31:0] wb_dat_i,
    input  logic        wb_ack_i,
    input  logic        wb_err_i
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUS  = 2'd1,
        S_RESP = 2'd2
    } state_t;

    // Last counter value before the cycle is abandoned; cyc stays up for exactly TIMEOUT cycles.
    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        cyc_q, cyc_d;
    logic        stb_q, stb_d;
    logic        we_q, we_d;
    logic [31:0] adr_q, adr_d;
    logic [31:0] dat_q, dat_d;
    logic [3:0]  sel_q, sel_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic [31:0] rsp_dat_q, rsp_dat_d;
    logic        rsp_err_q, rsp_err_d;
    logic        rsp_timeout_q, rsp_timeout_d;

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        cyc_d         = cyc_q;
        stb_d         = stb_q;
        we_d          = we_q;
        adr_d         = adr_q;
        dat_d         = dat_q;
        sel_d         = sel_q;
        rsp_valid_d   = rsp_valid_q;
        rsp_dat_d     = rsp_dat_q;
        rsp_err_d     = rsp_err_q;
        rsp_timeout_d = rsp_timeout_q;

        case (state_q)
            S_IDLE: begin
                if (req_valid_i) begin
                    adr_d   = req_adr_i;
                    dat_d   = req_dat_i;
                    sel_d   = req_sel_i;
                    we_d    = req_we_i;
                    cyc_d   = 1'b1;
                    stb_d   = 1'b1;
                    cnt_d   = 8'd0;
                    state_d = S_BUS;
                end
            end
            S_BUS: begin
                if (wb_err_i || wb_ack_i || (cnt_q == CNT_LAST)) begin
                    cyc_d       = 1'b0;
                    stb_d       = 1'b0;
                    we_d        = 1'b0;
                    rsp_valid_d = 1'b1;
                    state_d     = S_RESP;
                    // err beats ack, and a real ack beats a coincident timeout
                    if (wb_err_i) begin
                        rsp_err_d     = 1'b1;
                        rsp_timeout_d = 1'b0;
                        rsp_dat_d     = we_q ? 32'd0 : ERR_DATA;
                    end else if (wb_ack_i) begin
                        rsp_err_d     = 1'b0;
                        rsp_timeout_d = 1'b0;
                        rsp_dat_d     = we_q ? 32'd0 : wb_dat_i;
                    end else begin
                        rsp_err_d     = 1'b1;
                        rsp_timeout_d = 1'b1;
                        rsp_dat_d     = we_q ? 32'd0 : ERR_DATA;
                    end
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            S_RESP: begin
                if (rsp_ready_i) begin
                    rsp_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q       <= S_IDLE;
            cnt_q         <= 8'd0;
            cyc_q         <= 1'b0;
            stb_q         <= 1'b0;
            we_q          <= 1'b0;
            adr_q         <= 32'd0;
            dat_q         <= 32'd0;
            sel_q         <= 4'd0;
            rsp_valid_q   <= 1'b0;
            rsp_dat_q     <= 32'd0;
            rsp_err_q     <= 1'b0;
            rsp_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            cyc_q         <= cyc_d;
            stb_q         <= stb_d;
            we_q          <= we_d;
            adr_q         <= adr_d;
            dat_q         <= dat_d;
            sel_q         <= sel_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_dat_q     <= rsp_dat_d;
            rsp_err_q     <= rsp_err_d;
            rsp_timeout_q <= rsp_timeout_d;
        end
    end

    assign req_ready_o   = (state_q == S_IDLE);
    assign wb_cyc_o      = cyc_q;
    assign wb_stb_o      = stb_q;
    assign wb_we_o       = we_q;
    assign wb_adr_o      = adr_q;
    assign wb_dat_o      = dat_q;
    assign wb_sel_o      = sel_q;
    assign rsp_valid_o   = rsp_valid_q;
    assign rsp_dat_o     = rsp_dat_q;
    assign rsp_err_o     = rsp_err_q;
    assign rsp_timeout_o = rsp_timeout_q;

endmodule

// File: tb/tb_wb_master_bridge.sv
// Bench for wb_master_bridge: per-transaction timeline model (accept, bus window, response window)
// compared against the DUT every cycle, plus literal checks for the directed scenarios.
module tb_wb_master_bridge;

    localparam int          TMO  = 255;
    localparam logic [31:0] ERRD = 32'hDEAD_BEEF;

    logic        clk = 1'b0;
    logic        rst_i = 1'b1;
    logic        req_valid_i = 1'b0, req_ready_o, req_we_i = 1'b0;
    logic [31:0] req_adr_i = '0, req_dat_i = '0;
    logic [3:0]  req_sel_i = '0;
    logic        rsp_valid_o, rsp_ready_i = 1'b0, rsp_err_o, rsp_timeout_o;
    logic [31:0] rsp_dat_o;
    logic        wb_cyc_o, wb_stb_o, wb_we_o;
    logic [31:0] wb_adr_o, wb_dat_o, wb_dat_i = '0;
    logic [3:0]  wb_sel_o;
    logic        wb_ack_i = 1'b0, wb_err_i = 1'b0;

    wb_master_bridge #(.TIMEOUT(TMO), .ERR_DATA(ERRD)) dut (
        .clk_i(clk), .rst_i(rst_i),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_we_i(req_we_i),
        .req_adr_i(req_adr_i), .req_dat_i(req_dat_i), .req_sel_i(req_sel_i),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_dat_o(rsp_dat_o),
        .rsp_err_o(rsp_err_o), .rsp_timeout_o(rsp_timeout_o),
        .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o),
        .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel_o),
        .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    // Expected outputs for the current cycle, written by the stimulus timeline.
    logic        e_ready = 1'b1, e_cyc = 1'b0, e_we = 1'b0, e_rv = 1'b0, e_err = 1'b0, e_tmo = 1'b0;
    logic [31:0] e_adr = '0, e_dat = '0, e_rdat = '0;
    logic [3:0]  e_sel = '0;

    // Observed run lengths and first-cycle response capture.
    int          cyc_run = 0, last_cyc_len = 0, rv_run = 0, last_rv_len = 0;
    logic [31:0] cap_dat = '0;
    logic        cap_err = 1'b0, cap_tmo = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                chk("req_ready", 32'(req_ready_o), 32'(e_ready));
                chk("wb_cyc", 32'(wb_cyc_o), 32'(e_cyc));
                chk("wb_stb", 32'(wb_stb_o), 32'(e_cyc));
                chk("wb_we", 32'(wb_we_o), 32'(e_we));
                chk("wb_adr", wb_adr_o, e_adr);
                chk("wb_dat", wb_dat_o, e_dat);
                chk("wb_sel", 32'(wb_sel_o), 32'(e_sel));
                chk("rsp_valid", 32'(rsp_valid_o), 32'(e_rv));
                chk("rsp_dat", rsp_dat_o, e_rdat);
                chk("rsp_err", 32'(rsp_err_o), 32'(e_err));
                chk("rsp_timeout", 32'(rsp_timeout_o), 32'(e_tmo));
                if (wb_cyc_o) cyc_run++;
                else if (cyc_run != 0) begin last_cyc_len = cyc_run; cyc_run = 0; end
                if (rsp_valid_o) begin
                    if (rv_run == 0) begin cap_dat = rsp_dat_o; cap_err = rsp_err_o; cap_tmo = rsp_timeout_o; end
                    rv_run++;
                end else if (rv_run != 0) begin
                    last_rv_len = rv_run; rv_run = 0;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle_exp();
        e_ready = 1'b1; e_cyc = 1'b0; e_we = 1'b0; e_rv = 1'b0;
    endtask

    task automatic junk_req(input bit hold);
        req_valid_i = hold | 1'($urandom_range(0, 1));
        req_we_i    = 1'($urandom_range(0, 1));
        req_adr_i   = $urandom;
        req_dat_i   = $urandom;
        req_sel_i   = 4'($urandom);
    endtask

    task automatic idle(input int n, input bit noise);
        for (int i = 0; i < n; i++) begin
            tick();
            set_idle_exp();
            req_valid_i = 1'b0;
            rsp_ready_i = 1'($urandom_range(0, 1));
            wb_ack_i    = noise & 1'($urandom_range(0, 1));
            wb_err_i    = noise & 1'($urandom_range(0, 1));
            wb_dat_i    = $urandom;
        end
    endtask

    // resp_at = bus cycle (1-based) in which the slave answers; 0 means never.
    task automatic run_txn(input bit we, input logic [31:0] adr, input logic [31:0] dat,
                           input logic [3:0] sel, input int resp_at, input bit use_err,
                           input bit also_ack, input logic [31:0] rdat, input int bp,
                           input bit hold_req);
        int          len;
        bit          answered;
        logic [31:0] xd;
        logic        xe, xt;
        answered = (resp_at >= 1) && (resp_at <= TMO);
        len      = answered ? resp_at : TMO;
        if (answered && !use_err) begin
            xe = 1'b0; xt = 1'b0; xd = we ? 32'd0 : rdat;
        end else begin
            xe = 1'b1; xt = !answered; xd = we ? 32'd0 : ERRD;
        end
        tick();
        set_idle_exp();
        req_valid_i = 1'b1; req_we_i = we; req_adr_i = adr; req_dat_i = dat; req_sel_i = sel;
        wb_ack_i = 1'($urandom_range(0, 1)); wb_err_i = 1'($urandom_range(0, 1));
        rsp_ready_i = 1'($urandom_range(0, 1));
        for (int k = 1; k <= len; k++) begin
            tick();
            e_ready = 1'b0; e_cyc = 1'b1; e_we = we; e_rv = 1'b0;
            e_adr = adr; e_dat = dat; e_sel = sel;
            junk_req(hold_req);
            rsp_ready_i = 1'($urandom_range(0, 1));
            wb_dat_i = $urandom; wb_ack_i = 1'b0; wb_err_i = 1'b0;
            if (answered && k == resp_at) begin
                if (use_err) begin
                    wb_err_i = 1'b1; wb_ack_i = also_ack;
                end else begin
                    wb_ack_i = 1'b1; wb_dat_i = rdat;
                end
            end
        end
        for (int j = 0; j <= bp; j++) begin
            tick();
            e_ready = 1'b0; e_cyc = 1'b0; e_we = 1'b0; e_rv = 1'b1;
            e_rdat = xd; e_err = xe; e_tmo = xt;
            rsp_ready_i = (j == bp);
            junk_req(hold_req);
            wb_ack_i = 1'($urandom_range(0, 1)); wb_err_i = 1'($urandom_range(0, 1));
            wb_dat_i = $urandom;
        end
    endtask

    initial begin
        chk_en = 1'b1;
        #1;
        chk("reset_ready", 32'(req_ready_o), 32'd1);
        chk("reset_cyc", 32'(wb_cyc_o), 32'd0);
        chk("reset_rsp_valid", 32'(rsp_valid_o), 32'd0);
        #11 rst_i = 1'b0;

        // Zero-wait read
        run_txn(1'b0, 32'h3000_0004, 32'h0, 4'hF, 1, 1'b0, 1'b0, 32'h1234_5678, 0, 1'b0);
        idle(2, 1'b0);
        chk("d_read_cyc_len", 32'(last_cyc_len), 32'd1);
        chk("d_read_dat", cap_dat, 32'h1234_5678);
        chk("d_read_err", 32'(cap_err), 32'd0);

        // Write with three wait states
        run_txn(1'b1, 32'h3000_0010, 32'hA5A5_0001, 4'b0011, 4, 1'b0, 1'b0, 32'h5555_5555, 0, 1'b0);
        idle(2, 1'b1);
        chk("d_write_cyc_len", 32'(last_cyc_len), 32'd4);
        chk("d_write_dat", cap_dat, 32'd0);
        chk("d_write_err", 32'(cap_err), 32'd0);

        // err and ack together: err wins
        run_txn(1'b0, 32'h3000_0020, 32'h0, 4'hF, 2, 1'b1, 1'b1, 32'h1111_2222, 0, 1'b0);
        idle(2, 1'b0);
        chk("d_err_flag", 32'(cap_err), 32'd1);
        chk("d_err_tmo", 32'(cap_tmo), 32'd0);
        chk("d_err_dat", cap_dat, 32'hDEAD_BEEF);

        // Silent slave: timeout
        run_txn(1'b0, 32'h3000_0030, 32'h0, 4'hF, 0, 1'b0, 1'b0, 32'h0, 1, 1'b0);
        idle(2, 1'b0);
        chk("d_tmo_cyc_len", 32'(last_cyc_len), 32'd255);
        chk("d_tmo_err", 32'(cap_err), 32'd1);
        chk("d_tmo_flag", 32'(cap_tmo), 32'd1);
        chk("d_tmo_dat", cap_dat, 32'hDEAD_BEEF);

        // ack on the last permitted cycle completes normally
        run_txn(1'b0, 32'h3000_0034, 32'h0, 4'hF, 255, 1'b0, 1'b0, 32'hCAFE_0255, 0, 1'b0);
        idle(2, 1'b0);
        chk("d_late_cyc_len", 32'(last_cyc_len), 32'd255);
        chk("d_late_err", 32'(cap_err), 32'd0);
        chk("d_late_dat", cap_dat, 32'hCAFE_0255);

        // Response held for 10 cycles while the requester keeps req_valid high
        run_txn(1'b1, 32'h3000_0040, 32'h0BAD_F00D, 4'hC, 1, 1'b0, 1'b0, 32'h0, 10, 1'b1);
        run_txn(1'b0, 32'h3000_0044, 32'h0, 4'hF, 1, 1'b0, 1'b0, 32'h7777_8888, 0, 1'b0);
        idle(2, 1'b0);
        chk("d_bp_rv_len", 32'(last_rv_len), 32'd1);

        // Reset during cycle 2 of a waited read
        tick();
        set_idle_exp();
        req_valid_i = 1'b1; req_we_i = 1'b0; req_adr_i = 32'h3000_0050; req_sel_i = 4'hF;
        wb_ack_i = 1'b0; wb_err_i = 1'b0;
        tick();
        e_ready = 1'b0; e_cyc = 1'b1; e_we = 1'b0; e_adr = 32'h3000_0050; e_dat = req_dat_i; e_sel = 4'hF;
        req_valid_i = 1'b0;
        tick();
        chk_en = 1'b0;
        #1 rst_i = 1'b1;
        #1;
        chk("rst_cyc", 32'(wb_cyc_o), 32'd0);
        chk("rst_stb", 32'(wb_stb_o), 32'd0);
        chk("rst_ready", 32'(req_ready_o), 32'd1);
        chk("rst_adr", wb_adr_o, 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid_o), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_i = 1'b0;
        cyc_run = 0; rv_run = 0;
        tick();
        e_ready = 1'b1; e_cyc = 1'b0; e_we = 1'b0; e_rv = 1'b0; e_err = 1'b0; e_tmo = 1'b0;
        e_adr = '0; e_dat = '0; e_sel = '0; e_rdat = '0;
        wb_ack_i = 1'b1; wb_dat_i = 32'h9999_9999;
        chk_en = 1'b1;
        idle(3, 1'b1);

        // Randomized traffic
        for (int t = 0; t < 120; t++) begin
            int ra;
            idle($urandom_range(0, 2), 1'b1);
            ra = ($urandom_range(0, 29) == 0) ? 0 : int'($urandom_range(1, 5));
            run_txn(1'($urandom_range(0, 1)), $urandom, $urandom, 4'($urandom), ra,
                    ($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)), $urandom,
                    int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
        end
        idle(2, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/wb_master_bridge.md
# wb_master_bridge

Wishbone B4 classic single-transfer initiator inside `soc`. Converts a valid/ready request from an internal requester (debug/DMA engine) into one Wishbone cycle, captures data or error, and returns a valid/ready response. It is the initiator counterpart of the Caravel Wishbone responder port. A bus timeout guarantees that a missing or unresponsive slave cannot hang the requester.

## Interface
Parameters:
- `TIMEOUT`, 255: maximum cycles `wb_cyc_o` stays high without `ack`/`err`; range 1..255.
- `ERR_DATA`, 32'hDEAD_BEEF: value on `rsp_dat_o` for an error or timeout read.

Ports:
- `clk_i` input 1: single clock; all logic on the rising edge.
- `rst_i` input 1: reset; asynchronous assert, active-high.
- `req_valid_i` input 1: request valid.
- `req_ready_o` output 1: bridge can accept a request.
- `req_we_i` input 1: 1 = write, 0 = read.
- `req_adr_i` input 32: byte address, passed through unmodified.
- `req_dat_i` input 32: write data.
- `req_sel_i` input 4: byte lane selects.
- `rsp_valid_o` output 1: response valid.
- `rsp_ready_i` input 1: requester accepts the response.
- `rsp_dat_o` output 32: read data. 0 for writes. `ERR_DATA` for an error read.
- `rsp_err_o` output 1: slave `err` or timeout.
- `rsp_timeout_o` output 1: error was caused by timeout.
- `wb_cyc_o`, `wb_stb_o`, `wb_we_o` outputs 1: Wishbone control.
- `wb_adr_o` output 32, `wb_dat_o` output 32, `wb_sel_o` output 4: Wishbone address, data and selects.
- `wb_dat_i` input 32, `wb_ack_i` input 1, `wb_err_i` input 1: slave response.

## Operation
- States: IDLE, BUS, RESP. All outputs come from registers, except `req_ready_o`, which is `state==IDLE`.
- IDLE:
  - `req_ready_o`=1.
  - When `req_valid_i` is high, latch `we/adr/dat/sel` onto the `wb_*` outputs, set `wb_cyc_o` and `wb_stb_o` to 1, clear the timeout counter, and go to BUS.
- BUS:
  - `wb_cyc_o` and `wb_stb_o` are held high. Address, data, select and we are stable.
  - On `wb_err_i`: go to RESP with `rsp_err_o`=1 and `rsp_timeout_o`=0. `rsp_dat_o`=`ERR_DATA` for a read, 0 for a write.
  - Else on `wb_ack_i`: go to RESP with `rsp_err_o`=0. `rsp_dat_o`=`wb_dat_i` for a read, 0 for a write.
  - Else, if the counter equals `TIMEOUT-1`: go to RESP with `rsp_err_o`=1 and `rsp_timeout_o`=1. Data as for `err`.
  - Otherwise, increment the counter (8 bits, never wraps).
  - On any exit, `wb_cyc_o`, `wb_stb_o` and `wb_we_o` drop in the same edge.
- RESP:
  - `rsp_valid_o`=1; data and flags are held stable.
  - When `rsp_ready_i` is high, clear `rsp_valid_o` and go to IDLE.
- Boundary cases:
  - `ack` and `err` together: `err` wins.
  - `ack`/`err` in IDLE or RESP: ignored, no state change.
  - `ack` in the same cycle the counter hits `TIMEOUT-1`: `ack` wins, normal completion.
  - `req_valid_i` outside IDLE: ignored; the requester holds it.
  - `wb_adr_o`, `wb_dat_o` and `wb_sel_o` keep their last values after the cycle ends; slaves must qualify them with `stb`.
- Reset values: state IDLE. `req_ready_o`=1. `rsp_valid_o`, `rsp_err_o`, `rsp_timeout_o`, `wb_cyc_o`, `wb_stb_o` and `wb_we_o` are 0. `rsp_dat_o`, `wb_adr_o`, `wb_dat_o` and `wb_sel_o` are 0. Counter 0.
- Reset mid-transaction drops `wb_cyc_o`/`wb_stb_o` immediately (asynchronous) and discards any pending response.

## Timing
- Request handshake in cycle 0 → `wb_cyc_o`/`wb_stb_o` high from cycle 1.
- Slave `ack` sampled high in cycle m (m≥1) → in cycle m+1 `cyc`/`stb` are low and `rsp_valid_o` is high.
- Response handshake in cycle r → `req_ready_o` high in cycle r+1.
- Minimum 3 cycles per transfer: accept, bus with immediate ack, response with `rsp_ready_i` high.
- Timeout: `cyc` is high for exactly `TIMEOUT` cycles (cycles 1..TIMEOUT), then `rsp_valid_o` is high in cycle TIMEOUT+1.
- No pipelining; only one outstanding transfer.

## Test plan
- Read with zero-wait ack: request read at 0x3000_0004, slave acks in cycle 1 with 0x1234_5678. Required: `rsp_valid_o` in cycle 2 with `rsp_dat_o`=0x1234_5678, err=0.
- Write with 3 wait states: request write 0xA5A5_0001, sel=4'b0011 at 0x3000_0010, ack in cycle 4. Required: `wb_*` stable over cycles 1–4, `cyc` low in cycle 5, `rsp_dat_o`=0, err=0.
- Slave error: read, `wb_err_i` and `wb_ack_i` both high in cycle 2. Required: `rsp_err_o`=1, `rsp_timeout_o`=0, `rsp_dat_o`=0xDEAD_BEEF.
- Timeout at `TIMEOUT`=255 with no ack: `cyc` high for exactly 255 cycles, `rsp_valid_o` in cycle 256 with err=1, timeout=1. Repeat with ack in cycle 255: normal completion.
- Response backpressure: hold `rsp_ready_i`=0 for 10 cycles with `req_valid_i` high. Required: response stable, `req_ready_o`=0, no new `cyc`; next transfer starts the cycle after the handshake.
- Reset mid-transaction: assert `rst_i` in cycle 2 of a waited read. Required: `cyc`/`stb` low before the next edge, all outputs at reset values, no response; a later `ack` is ignored.
